order_translate_pipe: RTL and testbench

Parametrised, multi-lane successor to the k2 order-to-address translator in the NTT address-generation path. Each lane splits an order index into `NUM_DIGITS` digits of `DIGIT_W` bits and produces two outputs: a bank number BN (digit sum mod `RADIX`) and a memory address MA (`order >> DELTA`). The datapath is an accumulate-per-stage pipeline, with valid/ready flow control so the memory-access stage downstream can apply backpressure. It sits between the AGU order generator and the bank/memory arbiter.

---
 rtl/order_translate_pipe.sv | 171 +++++++++++++++++
 tb/tb_order_translate_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_translate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : order_translate_pipe
// Purpose  : Multi-lane order -> (bank number, memory address) translator with
//            per-digit accumulate pipeline and global-stall valid/ready flow.
//            Optional bank_conflict output: ORDER_TRANS_CONFLICT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module order_translate_pipe #(
   parameter int LANES      = 2,
   parameter int D_WIDTH    = 32,
   parameter int DIGIT_W    = 4,
   parameter int NUM_DIGITS = 4,
   parameter int RADIX      = 16,
   parameter int DELTA      = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [LANES*D_WIDTH-1:0] order,
   input  logic                     in_valid,
   input  logic                     in_done,
   input  logic [D_WIDTH-1:0]       in_l,
   output logic                     in_ready,
   output logic [LANES*D_WIDTH-1:0] ma_idx,
   output logic [LANES*D_WIDTH-1:0] bn_idx,
   output logic                     out_valid,
   output logic                     out_done,
   output logic [D_WIDTH-1:0]       out_l,
   input  logic                     out_ready
`ifdef ORDER_TRANS_CONFLICT_CHECK_EN
   ,
   output logic                     bank_conflict
`endif
);

   localparam int                 c_DW    = NUM_DIGITS * DIGIT_W;
   localparam int                 c_ACC_W = DIGIT_W + 2;
   localparam int                 c_LAST  = NUM_DIGITS - 1;
   localparam logic [c_ACC_W-1:0] c_RADIX = c_ACC_W'(RADIX);

   // acc < RADIX and digit < 2*RADIX, so two conditional subtracts are exact
   function automatic logic [c_ACC_W-1:0] f_mod(input logic [c_ACC_W-1:0] v);
      logic [c_ACC_W-1:0] t;
      t = v;
      if (t >= c_RADIX) t = t - c_RADIX;
      if (t >= c_RADIX) t = t - c_RADIX;
      return t;
   endfunction

   logic                 w_stall;
   logic [c_DW-1:0]      w_ord_in [LANES];
   logic                 w_unused_order;

   logic                 r_vld  [NUM_DIGITS];
   logic                 r_done [NUM_DIGITS];
   logic [D_WIDTH-1:0]   r_l    [NUM_DIGITS];
   logic [c_DW-1:0]      r_ord  [NUM_DIGITS][LANES];
   logic [c_ACC_W-1:0]   r_acc  [NUM_DIGITS][LANES];

   logic                     r_out_vld;
   logic                     r_out_done;
   logic [D_WIDTH-1:0]       r_out_l;
   logic [LANES*D_WIDTH-1:0] r_ma;
   logic [LANES*D_WIDTH-1:0] r_bn;
   logic [LANES*D_WIDTH-1:0] w_ma_nxt;
   logic [LANES*D_WIDTH-1:0] w_bn_nxt;

   assign w_stall        = r_out_vld & ~out_ready;
   assign in_ready       = ~w_stall & rst_n;
   assign w_unused_order = ^order;

   always_comb begin
      for (int ln = 0; ln < LANES; ln++) begin
         w_ord_in[ln] = order[ln*D_WIDTH +: c_DW];
      end
   end

   // Digit pipeline: stage 0 captures the beat, stage s folds in digit s
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_DIGITS; s++) begin
            r_vld[s]  <= 1'b0;
            r_done[s] <= 1'b0;
            r_l[s]    <= '0;
            for (int ln = 0; ln < LANES; ln++) begin
               r_ord[s][ln] <= '0;
               r_acc[s][ln] <= '0;
            end
         end
      end else if (!w_stall) begin
         r_vld[0]  <= in_valid;
         r_done[0] <= in_valid & in_done;
         r_l[0]    <= in_l;
         for (int ln = 0; ln < LANES; ln++) begin
            r_ord[0][ln] <= w_ord_in[ln];
            r_acc[0][ln] <= f_mod(c_ACC_W'(w_ord_in[ln][DIGIT_W-1:0]));
         end
         for (int s = 1; s < NUM_DIGITS; s++) begin
            r_vld[s]  <= r_vld[s-1];
            r_done[s] <= r_done[s-1];
            r_l[s]    <= r_l[s-1];
            for (int ln = 0; ln < LANES; ln++) begin
               r_ord[s][ln] <= r_ord[s-1][ln];
               r_acc[s][ln] <= f_mod(r_acc[s-1][ln]
                               + c_ACC_W'(r_ord[s-1][ln][s*DIGIT_W +: DIGIT_W]));
            end
         end
      end
   end

   always_comb begin
      w_ma_nxt = '0;
      w_bn_nxt = '0;
      for (int ln = 0; ln < LANES; ln++) begin
         if (r_vld[c_LAST]) begin
            w_ma_nxt[ln*D_WIDTH +: D_WIDTH] = D_WIDTH'(r_ord[c_LAST][ln][c_DW-1:DELTA]);
            w_bn_nxt[ln*D_WIDTH +: D_WIDTH] = D_WIDTH'(r_acc[c_LAST][ln]);
         end
      end
   end

   // Output register; bubbles load all-zero data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_vld  <= 1'b0;
         r_out_done <= 1'b0;
         r_out_l    <= '0;
         r_ma       <= '0;
         r_bn       <= '0;
      end else if (!w_stall) begin
         r_out_vld  <= r_vld[c_LAST];
         r_out_done <= r_vld[c_LAST] & r_done[c_LAST];
         r_out_l    <= r_vld[c_LAST] ? r_l[c_LAST] : '0;
         r_ma       <= w_ma_nxt;
         r_bn       <= w_bn_nxt;
      end
   end

   assign out_valid = r_out_vld;
   assign out_done  = r_out_done;
   assign out_l     = r_out_l;
   assign ma_idx    = r_ma;
   assign bn_idx    = r_bn;

`ifdef ORDER_TRANS_CONFLICT_CHECK_EN
   logic w_conf;
   logic r_conf;

   always_comb begin
      w_conf = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (r_acc[c_LAST][i] == r_acc[c_LAST][j]) w_conf = 1'b1;
         end
      end
      w_conf = w_conf & r_vld[c_LAST];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_conf <= 1'b0;
      end else if (!w_stall) begin
         r_conf <= w_conf;
      end
   end

   assign bank_conflict = r_conf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_order_translate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_order_translate_pipe
// Purpose  : Scoreboard bench for order_translate_pipe (RADIX 16 and 13 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_order_translate_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] order = '0;
   logic        in_valid = 1'b0;
   logic        in_done = 1'b0;
   logic [31:0] in_l = '0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, out_done;
   logic [63:0] ma_idx, bn_idx;
   logic [31:0] out_l;
   logic        in_ready13, out_valid13, out_done13;
   logic [63:0] ma13, bn13;
   logic [31:0] out_l13;
`ifdef ORDER_TRANS_CONFLICT_CHECK_EN
   logic        bank_conflict, bank_conflict13;
`endif

   always #5 clk = ~clk;

   order_translate_pipe dut (
      .clk(clk), .rst_n(rst_n), .order(order), .in_valid(in_valid),
      .in_done(in_done), .in_l(in_l), .in_ready(in_ready), .ma_idx(ma_idx),
      .bn_idx(bn_idx), .out_valid(out_valid), .out_done(out_done),
      .out_l(out_l), .out_ready(out_ready)
`ifdef ORDER_TRANS_CONFLICT_CHECK_EN
      , .bank_conflict(bank_conflict)
`endif
   );

   order_translate_pipe #(.RADIX(13)) dut13 (
      .clk(clk), .rst_n(rst_n), .order(order), .in_valid(in_valid),
      .in_done(in_done), .in_l(in_l), .in_ready(in_ready13), .ma_idx(ma13),
      .bn_idx(bn13), .out_valid(out_valid13), .out_done(out_done13),
      .out_l(out_l13), .out_ready(out_ready)
`ifdef ORDER_TRANS_CONFLICT_CHECK_EN
      , .bank_conflict(bank_conflict13)
`endif
   );

   typedef struct packed {
      logic [63:0] ma;
      logic [63:0] bn;
      logic [63:0] bn13;
      logic        done;
      logic [31:0] l;
      logic        conf;
      logic        conf13;
      logic [31:0] acc_cyc;
      logic [31:0] held_at;
      logic        seen;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   held = 0;
   int   vld_cnt = 0;
   int   done_cnt = 0;

   // Reference: digit sum mod radix, address = low 16 bits >> 4
   function automatic logic [31:0] m_bn(input logic [31:0] o, input int radix);
      int sum;
      sum = 0;
      for (int k = 0; k < 4; k++) sum += int'((o >> (4*k)) & 32'hF);
      return 32'(sum % radix);
   endfunction

   function automatic logic [31:0] m_ma(input logic [31:0] o);
      return (o & 32'hFFFF) >> 4;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard bookkeeping at each edge (pre-edge DUT values)
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_valid && !out_ready) held++;
         if (out_valid && out_ready) begin
            vld_cnt++;
            if (out_done) done_cnt++;
            if (q.size() > 0) void'(q.pop_front());
         end
         if (in_valid && in_ready) begin
            e.ma      = {m_ma(order[63:32]), m_ma(order[31:0])};
            e.bn      = {m_bn(order[63:32], 16), m_bn(order[31:0], 16)};
            e.bn13    = {m_bn(order[63:32], 13), m_bn(order[31:0], 13)};
            e.conf    = (m_bn(order[63:32], 16) == m_bn(order[31:0], 16));
            e.conf13  = (m_bn(order[63:32], 13) == m_bn(order[31:0], 13));
            e.done    = in_done;
            e.l       = in_l;
            e.acc_cyc = cyc;
            e.held_at = held;
            e.seen    = 1'b0;
            q.push_back(e);
         end
      end
   end

   // Per-cycle compare against the scoreboard front
   always @(negedge clk) begin
      exp_t e;
      chk("in_ready", {63'd0, in_ready}, {63'd0, rst_n & ~(out_valid & ~out_ready)});
      if (out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_beat", {63'd0, out_valid}, 64'd0);
         end else begin
            e = q[0];
            if (!e.seen) begin
               chk("latency", 64'(cyc - int'(e.acc_cyc)), 64'(4 + held - int'(e.held_at)));
               q[0].seen = 1'b1;
            end
            chk("ma", ma_idx, e.ma);
            chk("bn", bn_idx, e.bn);
            chk("done", {63'd0, out_done}, {63'd0, e.done});
            chk("l", {32'd0, out_l}, {32'd0, e.l});
`ifdef ORDER_TRANS_CONFLICT_CHECK_EN
            chk("conflict", {63'd0, bank_conflict}, {63'd0, e.conf});
`endif
         end
      end else begin
         chk("idle_zero", {ma_idx, bn_idx} | {out_l, 31'd0, out_done}, 128'd0);
`ifdef ORDER_TRANS_CONFLICT_CHECK_EN
         chk("idle_conflict", {63'd0, bank_conflict}, 64'd0);
`endif
      end
      if (out_valid13 && q.size() > 0) begin
         e = q[0];
         chk("r13_bn", bn13, e.bn13);
         chk("r13_ma", ma13, e.ma);
         chk("r13_l", {32'd0, out_l13}, {32'd0, e.l});
         chk("r13_done", {63'd0, out_done13}, {63'd0, e.done});
`ifdef ORDER_TRANS_CONFLICT_CHECK_EN
         chk("r13_conflict", {63'd0, bank_conflict13}, {63'd0, e.conf13});
`endif
      end else if (!out_valid13) begin
         chk("r13_idle_zero", {ma13, bn13} | {out_l13, 31'd0, out_done13}, 128'd0);
      end
      chk("r13_in_ready", {63'd0, in_ready13}, {63'd0, rst_n & ~(out_valid13 & ~out_ready)});
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send(input logic [31:0] o0, input logic [31:0] o1,
                       input logic [31:0] l, input logic d);
      logic a;
      int   n;
      order    = {o1, o0};
      in_l     = l;
      in_done  = d;
      in_valid = 1'b1;
      n        = 0;
      do begin
         @(negedge clk);
         a = in_ready;
         @(posedge clk);
         #2;
         n++;
      end while (!a && n < 50);
      if (!a) chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      in_done  = 1'b0;
   endtask

   task automatic wait_out(input string name);
      for (int k = 1; k <= 4; k++) begin
         idle(1);
         chk(name, {63'd0, out_valid}, {63'd0, (k == 4)});
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int sd;
      idle(2);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
      rst_n = 1'b1;

      // Basic translation
      send(32'h1234, 32'hFFFF, 32'd3, 1'b0);
      wait_out("basic_latency");
      chk("basic_bn", bn_idx, {32'hC, 32'hA});
      chk("basic_ma", ma_idx, {32'hFFF, 32'h123});
      chk("basic_l", {32'd0, out_l}, 64'd3);
      idle(1);
      chk("basic_one_cycle", {63'd0, out_valid}, 64'd0);

      // Radix-13 copy
      send(32'hFFFF, 32'h0C0C, 32'd7, 1'b0);
      wait_out("r13_latency");
      chk("r13_lit_bn", bn13, {32'd11, 32'd8});
      chk("r13_lit_ma", ma13, {32'h0C0, 32'hFFF});
      chk("r16_lit_bn", bn_idx, {32'd8, 32'hC});
      idle(2);

      // Streaming
      st = vld_cnt;
      sd = done_cnt;
      for (int n = 0; n < 8; n++)
         send(32'(n) * 32'h1111, 32'(7 - n) * 32'h1111, 32'(n), (n == 7));
      idle(8);
      chk("stream_count", 64'(vld_cnt - st), 64'd8);
      chk("stream_done_count", 64'(done_cnt - sd), 64'd1);

      // Backpressure with four beats in flight
      for (int n = 1; n <= 4; n++)
         send(32'h0101 * 32'(n), 32'h2200 + 32'(n), 32'(10 + n), 1'b0);
      idle(1);
      chk("bp_first_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_first_bn", bn_idx, {32'h5, 32'h2});
      out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               idle(1);
               chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
               chk("bp_hold_bn", bn_idx, {32'h5, 32'h2});
            end
            out_ready = 1'b1;
         end
         send(32'hAAAA, 32'h5555, 32'd9, 1'b0);
      join
      st = vld_cnt;
      idle(10);
      chk("bp_drain_count", 64'(vld_cnt - st), 64'd4);

      // Mid-stream reset
      for (int n = 0; n < 3; n++) send(32'h0F0F, 32'h0011, 32'd20, 1'b0);
      rst_n = 1'b0;
      idle(1);
      chk("mrst_valid", {63'd0, out_valid}, 64'd0);
      chk("mrst_data", {ma_idx, bn_idx}, 128'd0);
      chk("mrst_l_done", {31'd0, out_l, out_done}, 64'd0);
      rst_n = 1'b1;
      send(32'h4321, 32'h0001, 32'd5, 1'b1);
      wait_out("mrst_new_latency");
      chk("mrst_new_bn", bn_idx, {32'd1, 32'd10});
      chk("mrst_new_done", {63'd0, out_done}, 64'd1);
      chk("mrst_new_l", {32'd0, out_l}, 64'd5);
      idle(2);

`ifdef ORDER_TRANS_CONFLICT_CHECK_EN
      send(32'h0013, 32'h0022, 32'd1, 1'b0);
      wait_out("conf_latency_a");
      chk("conf_equal", {63'd0, bank_conflict}, 64'd1);
      idle(1);
      send(32'h0013, 32'h0023, 32'd2, 1'b0);
      wait_out("conf_latency_b");
      chk("conf_differ", {63'd0, bank_conflict}, 64'd0);
      idle(2);
`endif

      idle(4);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
